// File: rtl/grf_trace_fifo.sv
// Trace capture FIFO for committed GRF writes: filters $0, buffers records and
// presents them first-word-fall-through on a valid/ready port with drop accounting.
module grf_trace_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [4:0]                a3,
    input  logic [31:0]               wd,
    input  logic [31:0]               pc,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [31:0]               trace_pc,
    output logic [4:0]                trace_addr,
    output logic [31:0]               trace_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    // Handshake decode; a full FIFO still accepts when the head leaves on the same edge
    always_comb begin
        push_req = we && (a3 != 5'd0);
        pop      = (count != '0) && trace_ready;
        full     = (count == CW'(DEPTH));
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset; outputs mask it while empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{pc: pc, addr: a3, data: wd};
        end
    end

    always_comb begin
        head        = mem[rd_ptr];
        trace_valid = (count != '0);
        trace_pc    = '0;
        trace_addr  = '0;
        trace_data  = '0;
        if (trace_valid) begin
            trace_pc   = head.pc;
            trace_addr = head.addr;
            trace_data = head.data;
        end
    end

endmodule

// File: tb/tb_grf_trace_fifo.sv
// Scoreboard bench for grf_trace_fifo: stimulus pushes expected records into a queue,
// a negedge monitor pops and compares every accepted head record.
module tb_grf_trace_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } rec_t;

    rec_t       exp_q[$];
    int         mcnt;
    bit         movf;
    int         mdrop;
    int         errors;
    int         checks;
    logic [4:0] last_addr;

    grf_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .we(we), .a3(a3), .wd(wd), .pc(pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every handshake seen before the edge consumes the oldest expected record
    always @(negedge clk) begin
        if (reset === 1'b0 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got addr %0h expected none", trace_addr);
            end else begin
                rec_t e;
                e = exp_q.pop_front();
                chk("rec_addr", 64'(trace_addr), 64'(e.addr));
                chk("rec_data", 64'(trace_data), 64'(e.data));
                chk("rec_pc",   64'(trace_pc),   64'(e.pc));
                last_addr = trace_addr;
            end
        end
    end

    // Drive one cycle of inputs, advance the reference model, then check state after the edge
    task automatic step(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] p, input bit rdy);
        bit pop_m;
        we = w; a3 = a; wd = d; pc = p; trace_ready = rdy;
        pop_m = (mcnt > 0) && rdy;
        if (w && a != 5'd0) begin
            if (mcnt < int'(DEPTH) || pop_m) begin
                exp_q.push_back('{pc: p, addr: a, data: d});
                mcnt++;
            end else begin
                movf = 1'b1;
                if (mdrop < 65535) mdrop++;
            end
        end
        if (pop_m) mcnt--;
        @(posedge clk);
        #1;
        chk("count",    64'(count),       64'(mcnt));
        chk("valid",    64'(trace_valid), 64'(mcnt != 0));
        chk("overflow", 64'(overflow),    64'(movf));
        chk("drop_cnt", 64'(drop_cnt),    64'(mdrop));
        if (mcnt == 0) begin
            chk("empty_head", {27'd0, trace_addr, trace_pc}, 64'd0);
            chk("empty_data", 64'(trace_data), 64'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * int'(DEPTH) && mcnt > 0; i++) begin
            step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        end
        chk("drain_done", 64'(mcnt), 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        errors = 0; checks = 0; mcnt = 0; movf = 1'b0; mdrop = 0; last_addr = '0;
        reset = 1'b1; we = 1'b0; a3 = '0; wd = '0; pc = '0; trace_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_drop",  64'(drop_cnt), 64'd0);
        reset = 1'b0;

        // Single record, one-cycle latency, consumed on the next edge
        step(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b1);
        chk("t1_addr", 64'(trace_addr), 64'd5);
        chk("t1_data", 64'(trace_data), 64'h1234);
        chk("t1_pc",   64'(trace_pc),   64'h3000);
        step(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        chk("t1_count", 64'(count), 64'd0);

        // Writes to $0 are invisible
        repeat (4) step(1'b1, 5'd0, 32'hFFFF, 32'h4000, 1'b1);
        chk("t2_drop", 64'(drop_cnt), 64'd0);

        // Overfill by one
        for (int i = 1; i <= 9; i++) step(1'b1, 5'(i), 32'(i * 17), 32'h1000 + 32'(4 * i), 1'b0);
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_ovf",   64'(overflow), 64'd1);
        chk("t3_drop",  64'(drop_cnt), 64'd1);
        drain();
        chk("t3_last", 64'(last_addr), 64'd8);

        // Push into a full FIFO while it pops
        for (int i = 0; i < 8; i++) step(1'b1, 5'(10 + i), 32'(i), 32'h2000 + 32'(4 * i), 1'b0);
        step(1'b1, 5'd20, 32'hABCD, 32'h2100, 1'b1);
        chk("t4_count", 64'(count), 64'd8);
        chk("t4_drop",  64'(drop_cnt), 64'd1);
        drain();
        chk("t4_last", 64'(last_addr), 64'd20);

        // Streaming push+pop across pointer wrap
        step(1'b1, 5'd1, 32'h5000, 32'h6000, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 5'((i % 31) + 1), 32'h5001 + 32'(i), 32'h6004 + 32'(4 * i), 1'b1);
        chk("t5_count", 64'(count), 64'd1);
        drain();

        // Asynchronous reset mid-cycle with records pending
        for (int i = 0; i < 3; i++) step(1'b1, 5'(3 + i), 32'(i), 32'h7000, 1'b0);
        we = 1'b0; trace_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", 64'(trace_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ovf",   64'(overflow), 64'd0);
        chk("t6_drop",  64'(drop_cnt), 64'd0);
        exp_q.delete(); mcnt = 0; movf = 1'b0; mdrop = 0;
        reset = 1'b0;
        step(1'b1, 5'd7, 32'h7777, 32'h7700, 1'b0);
        chk("t6_alone", 64'(count), 64'd1);
        drain();
        chk("t6_last", 64'(last_addr), 64'd7);

        // Random traffic with alternating consumer pressure
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            bit rdy;
            a   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            step(1'($urandom_range(0, 1)), a, $urandom, $urandom, rdy);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
